uart_tx_queue: RTL and testbench

//  Byte FIFO plus handshake FSM that sits directly upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_txq_mem.sv | 23 ++
 rtl/uart_tx_queue.sv | 119 +++++++++++
 tb/tb_uart_tx_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, BUSY} txq_state_t;
endpackage

// File: rtl/uart_txq_mem.sv
// DEPTH x UART_DATA_W storage for the transmit queue.
// Writes are synchronous; the read port is combinational and indexed by the read pointer.
module uart_txq_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [UART_DATA_W-1:0] o_rd_data
);
  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus valid/rdy handshake FSM feeding a UART transmitter.
// Optional UART_TXQ_DROPCNT_EN adds a saturating drop_count output.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk100MHz,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow,
  output logic                   tx_valid,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_rdy
`ifdef UART_TXQ_DROPCNT_EN
  ,
  output logic [7:0]             drop_count
`endif
);
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_overflow;
  logic                   r_tx_valid;
  logic [UART_DATA_W-1:0] r_tx_data;
  txq_state_t             r_state;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [AW:0]            w_count_next;
  logic [UART_DATA_W-1:0] w_rd_data;

  // A push into a full queue survives only when the FSM frees a slot in the same cycle.
  assign w_pop  = (r_state == IDLE) && !r_empty && tx_rdy;
  assign w_push = wr_en && (!r_full || w_pop);
  assign w_drop = wr_en && r_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  uart_txq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk100MHz),
    .i_we      (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == (AW+1)'(DEPTH));
      r_empty    <= (w_count_next == '0);
      r_overflow <= w_drop;
    end
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          r_tx_data  <= w_rd_data;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end
        // Transmitter signals acceptance by dropping rdy.
        SEND: if (!tx_rdy) begin
          r_tx_valid <= 1'b0;
          r_state    <= BUSY;
        end
        BUSY: if (tx_rdy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_DROPCNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst)                                r_drop_count <= '0;
    else if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
  end

  assign drop_count = r_drop_count;
`endif

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a shortened-frame transmitter model.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_rdy = 1'b1;
  logic       full, empty, overflow, tx_valid;
  logic [AW:0] count;
  logic [7:0] tx_data;
`ifdef UART_TXQ_DROPCNT_EN
  logic [7:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk100MHz (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy)
`ifdef UART_TXQ_DROPCNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Transmitter model: frame time is shortened to keep runs short.
  bit         model_en  = 1'b0;
  bit         model_rand = 1'b0;
  int         frame_len = 20;
  int         rdy_violations = 0;
  logic [7:0] rx_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (model_en && tx_valid && tx_rdy) begin
        rx_q.push_back(tx_data);
        repeat (model_rand ? int'($urandom_range(0, 3)) : 1) @(negedge clk);
        tx_rdy = 1'b0;
        repeat (model_rand ? int'($urandom_range(2, 8)) : frame_len) begin
          @(negedge clk);
          if (tx_valid) rdy_violations++;
        end
        tx_rdy = 1'b1;
      end
    end
  end

  task automatic do_reset();
    model_en = 1'b0;
    wr_en    = 1'b0;
    tx_rdy   = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_model_idle();
    for (int i = 0; i < 200 && !(tx_rdy && !tx_valid); i++) @(negedge clk);
    model_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
`ifdef UART_TXQ_DROPCNT_EN
    checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", drop_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h41;
    @(negedge clk); wr_en = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b exp 0", tx_valid); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", tx_valid); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h exp 41", tx_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", count); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid_hold got %b exp 1", tx_valid); end
    tx_rdy = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b exp 0", tx_valid); end
    checks++; if (dut.r_state !== BUSY) begin errors++; $display("FAIL single_busy got %0d exp %0d", dut.r_state, BUSY); end
    repeat (3) @(negedge clk);
    tx_rdy = 1'b1;
    @(negedge clk);
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL single_idle got %0d exp %0d", dut.r_state, IDLE); end
    $display("single: sent 41");
  endtask

  task automatic test_hello();
    logic [7:0] exp_b [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    do_reset();
    rx_q.delete();
    rdy_violations = 0;
    model_rand = 1'b0;
    frame_len = 20;
    model_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = exp_b[i];
    end
    @(negedge clk); wr_en = 1'b0;
    for (int i = 0; i < 2000 && rx_q.size() < 5; i++) @(negedge clk);
    wait_model_idle();
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL hello_size got %0d exp 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      $display("hello: byte %0d = %h", i, rx_q[i]);
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL hello_byte%0d got %h exp %h", i, rx_q[i], exp_b[i]); end
    end
    checks++; if (rdy_violations != 0) begin errors++; $display("FAIL hello_valid_while_busy got %0d exp 0", rdy_violations); end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk); wr_data = 8'hEE;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
    @(negedge clk); wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold got %0d exp 16", count); end
`ifdef UART_TXQ_DROPCNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop_count got %0d exp 1", drop_count); end
`endif
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got %b exp 0", overflow); end
    $display("overflow: 17 pushes, 1 dropped");
  endtask

  task automatic test_full_pop();
    @(negedge clk); tx_rdy = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk); wr_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpop_count got %0d exp 16", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpop_full got %b exp 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b exp 0", overflow); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin errors++; $display("FAIL fullpop_out got v=%b d=%h exp v=1 d=10", tx_valid, tx_data); end
    rx_q.delete();
    model_rand = 1'b0;
    frame_len = 4;
    model_en = 1'b1;
    for (int i = 0; i < 2000 && rx_q.size() < 17; i++) @(negedge clk);
    wait_model_idle();
    checks++; if (rx_q.size() != 17) begin errors++; $display("FAIL fullpop_drain_size got %0d exp 17", rx_q.size()); end
    if (rx_q.size() == 17) begin
      checks++; if (rx_q[16] !== 8'hAA) begin errors++; $display("FAIL fullpop_last got %h exp AA", rx_q[16]); end
    end
    $display("full_pop: drained %0d bytes", rx_q.size());
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    tx_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h21 + 8'(i);
    end
    @(negedge clk); wr_en = 1'b0; tx_rdy = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || count !== 5'd3) begin errors++; $display("FAIL rstmid_pre got v=%b c=%0d exp v=1 c=3", tx_valid, count); end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", tx_valid); end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_state got c=%0d e=%b exp c=0 e=1", count, empty); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk); wr_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = tx_valid;
    end
    checks++; if (!seen || tx_data !== 8'h5A) begin errors++; $display("FAIL rstmid_fresh got v=%b d=%h exp v=1 d=5A", seen, tx_data); end
    tx_rdy = 1'b0;
    @(negedge clk); tx_rdy = 1'b1;
    @(negedge clk);
    $display("reset_mid: fresh byte %h", tx_data);
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    int sent = 0;
    do_reset();
    rx_q.delete();
    rdy_violations = 0;
    model_rand = 1'b1;
    model_en = 1'b1;
    for (int cyc = 0; cyc < 5000 && sent < 40; cyc++) begin
      @(negedge clk);
      if (!full && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_data = 8'(sent * 7 + 3);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk); wr_en = 1'b0;
    for (int i = 0; i < 5000 && rx_q.size() < 40; i++) @(negedge clk);
    wait_model_idle();
    checks++; if (rx_q.size() != 40) begin errors++; $display("FAIL stream_size got %0d exp 40", rx_q.size()); end
    for (int i = 0; i < 40 && i < rx_q.size() && i < exp_q.size(); i++) begin
      $display("stream: byte %0d = %h", i, rx_q[i]);
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (rdy_violations != 0) begin errors++; $display("FAIL stream_valid_while_busy got %0d exp 0", rdy_violations); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hello();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
